// File: rtl/issue_control_if.sv
// Decode/execute/memory/icache bundle seen by the issue controller.
// The slave modport is the controller; the master modport is its environment.
interface issue_control_if #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1)
);
  logic             dec_valid;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic [4:0]       dec_rd;
  logic             dec_rxs1;
  logic             dec_rxs2;
  logic             dec_wxd;
  logic             dec_mem;
  logic             dec_mem_wr;
  logic             dec_fence;
  logic             dec_fence_i;
  logic             dec_csr;
  logic             ex_ready;
  logic             kill;
  logic             mem_resp_valid;
  logic             mem_resp_wxd;
  logic [4:0]       mem_resp_rd;
  logic             flush_done;
  logic             issue;
  logic             icache_flush;
  logic [CNT_W-1:0] outstanding;
  logic             busy;
  logic [1:0]       state;

  // Handshake: an instruction transfers (and leaves decode) exactly in a
  // cycle where issue is high; issue already folds in dec_valid, ex_ready
  // and kill, so neither side re-qualifies it.
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rxs1, dec_rxs2, dec_wxd,
    output dec_mem, dec_mem_wr, dec_fence, dec_fence_i, dec_csr,
    output ex_ready, kill, mem_resp_valid, mem_resp_wxd, mem_resp_rd, flush_done,
    input  issue, icache_flush, outstanding, busy, state
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rxs1, dec_rxs2, dec_wxd,
    input  dec_mem, dec_mem_wr, dec_fence, dec_fence_i, dec_csr,
    input  ex_ready, kill, mem_resp_valid, mem_resp_wxd, mem_resp_rd, flush_done,
    output issue, icache_flush, outstanding, busy, state
  );
endinterface

// File: rtl/issue_control.sv
// Issue controller: load scoreboard, in-flight memory op counter and a
// drain/flush sequencer for FENCE, FENCE_I and CSR instructions.
module issue_control #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          reset,
  issue_control_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DRAIN      = 2'd1,
    FLUSH_REQ  = 2'd2,
    FLUSH_WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             killed_q;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue_d;
  logic             serial, hazard, drained, full;
  logic             cnt_inc, cnt_dec;

  assign serial  = bus.dec_fence | bus.dec_fence_i | bus.dec_csr;
  assign drained = (cnt_q == '0) && (pend_q == '0);
  // A response in the same cycle frees a slot, so a full counter does not
  // block a new memory op then; the register scoreboard has no such bypass.
  assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING)) && !bus.mem_resp_valid;
  assign hazard  = (bus.dec_rxs1 & pend_q[bus.dec_rs1]) |
                   (bus.dec_rxs2 & pend_q[bus.dec_rs2]) |
                   (bus.dec_wxd  & pend_q[bus.dec_rd])  |
                   (bus.dec_mem  & full);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      killed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == RUN)
        killed_q <= 1'b0;
      else if (bus.kill && (state_q == FLUSH_REQ || state_q == FLUSH_WAIT))
        killed_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.dec_valid && serial && !bus.kill)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.kill)
          state_d = RUN;
        else if (bus.dec_valid && drained) begin
          if (bus.dec_fence_i)
            state_d = FLUSH_REQ;
          else if (bus.ex_ready)
            state_d = RUN;
        end
      end
      FLUSH_REQ: state_d = FLUSH_WAIT;
      FLUSH_WAIT: begin
        // A killed FENCE_I still waits for its flush, then leaves silently.
        if (bus.flush_done && (bus.ex_ready || killed_q || bus.kill))
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    issue_d = 1'b0;
    case (state_q)
      RUN:        issue_d = bus.dec_valid & bus.ex_ready & ~bus.kill & ~hazard & ~serial;
      DRAIN:      issue_d = bus.dec_valid & bus.ex_ready & ~bus.kill & drained & ~bus.dec_fence_i;
      FLUSH_WAIT: issue_d = bus.dec_valid & bus.ex_ready & ~bus.kill & ~killed_q & bus.flush_done;
      default:    issue_d = 1'b0;
    endcase
  end

  assign bus.issue        = issue_d & ~reset;
  assign bus.icache_flush = (state_q == FLUSH_REQ);
  assign bus.busy         = (state_q != RUN);
  assign bus.state        = state_q;
  assign bus.outstanding  = cnt_q;

  // Scoreboard: only issued loads that write a real register become pending.
  always_comb begin
    pend_d = pend_q;
    if (bus.mem_resp_valid && bus.mem_resp_wxd)
      pend_d[bus.mem_resp_rd] = 1'b0;
    if (bus.issue && bus.dec_mem && !bus.dec_mem_wr && bus.dec_wxd)
      pend_d[bus.dec_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  assign cnt_inc = bus.issue & bus.dec_mem;
  assign cnt_dec = bus.mem_resp_valid & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // A response with nothing in flight is a protocol error by the memory side.
  resp_without_op: assert property (@(posedge clk) disable iff (reset)
    !(bus.mem_resp_valid && cnt_q == '0));

endmodule
